// File: rtl/mst_rcv_buf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mst_rcv_buf_pkg: shared master-path sizes and field split            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mst_rcv_buf_pkg;

  localparam int C_ADDRBIT = 2;
  localparam int C_LENGTH  = 1 << C_ADDRBIT;
  localparam int C_BE_W    = 4;
  localparam int C_WIDTH   = C_BE_W + 32;
  localparam int C_NCHAN   = 4;

  typedef logic [C_BE_W-1:0]          be_t;
  typedef logic [$clog2(C_NCHAN)-1:0] chn_t;

endpackage
`default_nettype wire

// File: rtl/mst_rcv_buf_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mst_rcv_buf_if: receive-side write port and four checker handshakes  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface mst_rcv_buf_if
  import mst_rcv_buf_pkg::*;
#(
  parameter int WIDTH = C_WIDTH
);

  logic                    rcvena;
  logic                    rcvwr;
  chn_t                    rcvchn;
  logic [WIDTH-1:0]        rcvdin;
  logic [C_NCHAN-1:0]      rcvnfull;
  logic [C_NCHAN-1:0]      rcvovf;

  logic                    chk0vld, chk1vld, chk2vld, chk3vld;
  logic                    chk0rdy, chk1rdy, chk2rdy, chk3rdy;
  be_t                     chk0be,  chk1be,  chk2be,  chk3be;
  logic [WIDTH-C_BE_W-1:0] chk0dat, chk1dat, chk2dat, chk3dat;

  modport master (
    output rcvena, rcvwr, rcvchn, rcvdin,
    output chk0rdy, chk1rdy, chk2rdy, chk3rdy,
    input  rcvnfull, rcvovf,
    input  chk0vld, chk1vld, chk2vld, chk3vld,
    input  chk0be,  chk1be,  chk2be,  chk3be,
    input  chk0dat, chk1dat, chk2dat, chk3dat
  );

  modport slave (
    input  rcvena, rcvwr, rcvchn, rcvdin,
    input  chk0rdy, chk1rdy, chk2rdy, chk3rdy,
    output rcvnfull, rcvovf,
    output chk0vld, chk1vld, chk2vld, chk3vld,
    output chk0be,  chk1be,  chk2be,  chk3be,
    output chk0dat, chk1dat, chk2dat, chk3dat
  );

endinterface
`default_nettype wire

// File: rtl/mst_rcv_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mst_rcv_fifo: one receive channel (storage, pointers, length, ovf)   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mst_rcv_fifo
  import mst_rcv_buf_pkg::*;
#(
  parameter int ADDRBIT = C_ADDRBIT,
  parameter int LENGTH  = C_LENGTH,
  parameter int WIDTH   = C_WIDTH
) (
  input  wire logic                    clk,
  input  wire logic                    rst_n,
  input  wire logic                    wr_req,
  input  wire logic [WIDTH-1:0]        din,
  input  wire logic                    rdy,
  output logic                         vld,
  output be_t                          be,
  output logic [WIDTH-C_BE_W-1:0]      dat,
  output logic                         nfull,
  output logic                         ovf
);

  localparam logic [ADDRBIT:0] C_FULL      = (ADDRBIT+1)'(LENGTH);
  localparam logic [ADDRBIT:0] C_NFULL_MAX = (ADDRBIT+1)'(LENGTH-2);

  logic [WIDTH-1:0]   r_mem [LENGTH];
  logic [ADDRBIT-1:0] r_wrptr;
  logic [ADDRBIT-1:0] r_rdptr;
  logic [ADDRBIT:0]   r_len;
  logic               r_ovf;

  logic               w_full;
  logic               w_rd;
  logic               w_wr;
  logic               w_drop;
  logic [WIDTH-1:0]   w_head;

  assign w_full = (r_len == C_FULL);
  assign vld    = (r_len != '0);
  assign w_rd   = vld & rdy;
  // A pop in the same cycle frees the slot, so a full channel still accepts.
  assign w_wr   = wr_req & (~w_full | w_rd);
  assign w_drop = wr_req & w_full & ~w_rd;

  assign w_head = r_mem[r_rdptr];
  assign be     = w_head[WIDTH-1 -: C_BE_W];
  assign dat    = w_head[WIDTH-C_BE_W-1:0];
  assign nfull  = (r_len <= C_NFULL_MAX);
  assign ovf    = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LENGTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wrptr <= '0;
      r_rdptr <= '0;
      r_len   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wrptr] <= din;
        r_wrptr        <= r_wrptr + ADDRBIT'(1);
      end
      if (w_rd) begin
        r_rdptr <= r_rdptr + ADDRBIT'(1);
      end
      if (w_wr && !w_rd) begin
        r_len <= r_len + (ADDRBIT+1)'(1);
      end else if (!w_wr && w_rd) begin
        r_len <= r_len - (ADDRBIT+1)'(1);
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mst_rcv_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mst_rcv_buf: four-channel receive buffer feeding the checkers        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mst_rcv_buf
  import mst_rcv_buf_pkg::*;
#(
  parameter int ADDRBIT = C_ADDRBIT,
  parameter int LENGTH  = C_LENGTH,
  parameter int WIDTH   = C_WIDTH
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  mst_rcv_buf_if.slave bus
);

  localparam int C_DAT_W = WIDTH - C_BE_W;

  wire [C_NCHAN-1:0] w_wr_req;
  wire [C_NCHAN-1:0] w_rdy;
  wire [C_NCHAN-1:0] w_vld;
  wire [C_NCHAN-1:0] w_nfull;
  wire [C_NCHAN-1:0] w_ovf;
  wire [C_BE_W-1:0]  w_be  [C_NCHAN];
  wire [C_DAT_W-1:0] w_dat [C_NCHAN];

  assign w_rdy = {bus.chk3rdy, bus.chk2rdy, bus.chk1rdy, bus.chk0rdy};

  genvar gi;
  for (gi = 0; gi < C_NCHAN; gi++) begin : g_chan
    assign w_wr_req[gi] = bus.rcvena & bus.rcvwr & (bus.rcvchn == chn_t'(gi));

    mst_rcv_fifo #(
      .ADDRBIT (ADDRBIT),
      .LENGTH  (LENGTH),
      .WIDTH   (WIDTH)
    ) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_req (w_wr_req[gi]),
      .din    (bus.rcvdin),
      .rdy    (w_rdy[gi]),
      .vld    (w_vld[gi]),
      .be     (w_be[gi]),
      .dat    (w_dat[gi]),
      .nfull  (w_nfull[gi]),
      .ovf    (w_ovf[gi])
    );
  end

  assign bus.rcvnfull = w_nfull;
  assign bus.rcvovf   = w_ovf;

  assign bus.chk0vld = w_vld[0];
  assign bus.chk1vld = w_vld[1];
  assign bus.chk2vld = w_vld[2];
  assign bus.chk3vld = w_vld[3];
  assign bus.chk0be  = w_be[0];
  assign bus.chk1be  = w_be[1];
  assign bus.chk2be  = w_be[2];
  assign bus.chk3be  = w_be[3];
  assign bus.chk0dat = w_dat[0];
  assign bus.chk1dat = w_dat[1];
  assign bus.chk2dat = w_dat[2];
  assign bus.chk3dat = w_dat[3];

endmodule
`default_nettype wire
